// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch front end for the RV32I 5-stage pipeline.
//             Issues sequential fetch requests to an in-order, variable
//             latency instruction memory, buffers the returned words with
//             their PCs in a reserved-slot queue and hands them to decode
//             under stall backpressure. Taken branch/jump redirects flush the
//             queue and discard stale in-flight responses.
//  Options  : FQ_BYPASS_EN - when defined, a response landing on the empty
//             head slot is presented to decode in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [31:0]                imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                InstrF,
    output logic [31:0]                PCF,
    output logic [31:0]                PCPlus4F,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int              c_ptr_w   = $clog2(DEPTH);
    localparam int              c_cnt_w   = $clog2(DEPTH+1);
    localparam int              c_dis_w   = c_cnt_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [31:0]     c_nop     = 32'h0000_0013;

    localparam logic [0:0]      c_st_run   = 1'b0;
    localparam logic [0:0]      c_st_drain = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [31:0]        r_fetch_pc;
    logic [c_ptr_w-1:0] r_req_ptr;
    logic [c_ptr_w-1:0] r_rsp_ptr;
    logic [c_ptr_w-1:0] r_head;
    logic [c_cnt_w-1:0] r_occ;
    logic [c_cnt_w-1:0] r_inflight;   // accepted requests still awaiting a response
    logic [c_dis_w-1:0] r_discard;    // stale responses still to be dropped
    logic [31:0]        r_last_pc;    // PC shown while the queue is empty
    logic [31:0]        r_slot_pc    [DEPTH];
    logic [31:0]        r_slot_instr [DEPTH];
    logic [DEPTH-1:0]   r_slot_full;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_run;
    logic               w_req_valid;
    logic               w_accept;
    logic               w_rsp_keep;
    logic               w_head_full;
    logic               w_bypass;
    logic               w_deq_valid;
    logic               w_deq;
    logic               w_fill;
    logic [c_cnt_w-1:0] w_inflight_left;
    logic [c_dis_w-1:0] w_discard_left;
    logic [c_dis_w-1:0] w_discard_redir;

    assign w_run       = (r_state == c_st_run);
    assign w_req_valid = w_run && !reset && !redirect && (r_occ < c_depth);
    assign w_accept    = w_req_valid && imem_req_ready;

    // A response is only kept in RUN, outside a redirect, and when a request
    // is actually outstanding; anything else is a stray and is ignored.
    assign w_rsp_keep  = imem_rsp_valid && w_run && !redirect && (r_inflight != '0);
    assign w_head_full = r_slot_full[r_head];

`ifdef FQ_BYPASS_EN
    // Head slot is reserved but empty and the response is for it: forward it.
    assign w_bypass    = w_rsp_keep && (r_rsp_ptr == r_head) && !w_head_full;
`else
    assign w_bypass    = 1'b0;
`endif

    assign w_deq_valid = (w_head_full || w_bypass) && !redirect && !reset;
    assign w_deq       = w_deq_valid && deq_ready;

    // A bypassed word consumed this cycle never needs to occupy its slot.
    assign w_fill      = w_rsp_keep && !(w_bypass && deq_ready);

    // Outstanding counts after accounting for a response arriving this
    // cycle; a redirect only has to discard what is still left after it.
    assign w_inflight_left = (w_run && imem_rsp_valid && (r_inflight != '0))
                           ? r_inflight - 1'b1 : r_inflight;
    assign w_discard_left  = (!w_run && imem_rsp_valid && (r_discard != '0))
                           ? r_discard - 1'b1 : r_discard;
    assign w_discard_redir = w_discard_left + c_dis_w'(w_inflight_left);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign deq_valid      = w_deq_valid;
    assign InstrF         = !w_deq_valid ? c_nop
                          : (w_bypass ? imem_rsp_data : r_slot_instr[r_head]);
    assign PCF            = w_deq_valid ? r_slot_pc[r_head] : r_last_pc;
    assign PCPlus4F       = PCF + 32'd4;
    assign occupancy      = r_occ;

    // Pointers, counters, slot valid bits and the RUN/DRAIN state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_run;
            r_fetch_pc  <= RESET_PC;
            r_req_ptr   <= '0;
            r_rsp_ptr   <= '0;
            r_head      <= '0;
            r_occ       <= '0;
            r_inflight  <= '0;
            r_discard   <= '0;
            r_slot_full <= '0;
            r_last_pc   <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc  <= redirect_pc;
            r_req_ptr   <= '0;
            r_rsp_ptr   <= '0;
            r_head      <= '0;
            r_occ       <= '0;
            r_inflight  <= '0;
            r_slot_full <= '0;
            r_discard   <= w_discard_redir;
            r_state     <= (w_discard_redir != '0) ? c_st_drain : c_st_run;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_req_ptr  <= r_req_ptr + 1'b1;
            end
            if (w_rsp_keep) begin
                r_rsp_ptr <= r_rsp_ptr + 1'b1;
            end
            if (w_deq) begin
                r_head    <= r_head + 1'b1;
                r_last_pc <= r_slot_pc[r_head];
            end
            r_occ      <= r_occ + c_cnt_w'(w_accept) - c_cnt_w'(w_deq);
            r_inflight <= r_inflight + c_cnt_w'(w_accept) - c_cnt_w'(w_rsp_keep);

            // Head, fill and request slots never coincide when all three
            // operations happen together, so the order here is immaterial.
            if (w_deq) begin
                r_slot_full[r_head] <= 1'b0;
            end
            if (w_fill) begin
                r_slot_full[r_rsp_ptr] <= 1'b1;
            end
            if (w_accept) begin
                r_slot_full[r_req_ptr] <= 1'b0;
            end

            if (!w_run) begin
                r_discard <= w_discard_left;
                if (w_discard_left == '0) begin
                    r_state <= c_st_run;
                end
            end
        end
    end

    // Slot payload storage; contents are qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slot_pc[r_req_ptr] <= r_fetch_pc;
        end
        if (w_fill) begin
            r_slot_instr[r_rsp_ptr] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue with an in-order
//             fixed-latency instruction memory model. Expectations adapt to
//             FQ_BYPASS_EN where same-cycle forwarding changes timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_nop = 32'h0000_0013;

`ifdef FQ_BYPASS_EN
    localparam int c_byp = 1;
`else
    localparam int c_byp = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [2:0]  occupancy;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        mq[$];
    int          cyc;
    int          mem_lat;
    int          n_vec;
    int          n_bad;
    int          first_deq_cyc;
    int          base_cyc;
    logic [31:0] exp_pc;
    logic        mon_en;
    logic        use_force;
    logic [31:0] force_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Present the oldest due response, if any, for the current cycle.
    task automatic set_rsp();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    // One clock cycle: sample handshakes, check dequeues, advance memory model.
    task automatic tick();
        logic        acc;
        logic        rv;
        logic [31:0] a;
        rsp_t        e;
        #2;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rv  = imem_rsp_valid;
        if (mon_en && !reset && deq_valid && deq_ready) begin
            check_val("deq_pc",    PCF,      exp_pc);
            check_val("deq_instr", InstrF,   mem_word(exp_pc));
            check_val("deq_pc4",   PCPlus4F, exp_pc + 32'd4);
            if (first_deq_cyc < 0) first_deq_cyc = cyc;
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (rv) mq.delete(0);
            if (acc) begin
                e.due  = cyc + mem_lat;
                e.data = use_force ? force_data : mem_word(a);
                mq.push_back(e);
            end
        end
        cyc++;
        #1;
        set_rsp();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        tick();
        settle();
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_deq_valid", 32'(deq_valid),      32'd0);
        check_val("rst_instr",     InstrF,              c_nop);
        check_val("rst_pc",        PCF,                 32'h0);
        check_val("rst_pc4",       PCPlus4F,            32'h4);
        check_val("rst_occ",       32'(occupancy),      32'd0);
        tick();
        reset         = 1'b0;
        cyc           = 0;
        exp_pc        = 32'h0;
        first_deq_cyc = -1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; mem_lat = 1;
        mon_en = 1'b1; use_force = 1'b0; force_data = 32'h0;
        exp_pc = 0; first_deq_cyc = -1; base_cyc = 0;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; deq_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // Streaming, 1-cycle memory, decode never stalls.
        do_reset();
        settle();
        check_val("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("t1_req_addr",  imem_req_addr,       32'h0);
        repeat (12) tick();
        settle();
        check_val("t1_first_deq", 32'(first_deq_cyc), 32'(2 - c_byp));
        check_val("t1_occ",       32'(occupancy),     32'(2 - c_byp));
        check_val("t1_deq_count", exp_pc,             (c_byp != 0) ? 32'h2C : 32'h28);

        // Decode stalled: queue saturates, head stays put, then drains in order.
        do_reset();
        deq_ready = 1'b0;
        repeat (10) tick();
        settle();
        check_val("t2_occ",       32'(occupancy),      32'd4);
        check_val("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("t2_deq_valid", 32'(deq_valid),      32'd1);
        check_val("t2_pc",        PCF,                 32'h0);
        check_val("t2_instr",     InstrF,              mem_word(32'h0));
        deq_ready = 1'b1;
        repeat (4) tick();
        settle();
        check_val("t2_release", exp_pc, 32'h10);

        // Redirect with two requests in flight, 3-cycle memory.
        do_reset();
        mem_lat = 3;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0100;
        exp_pc         = 32'h0000_0100;
        first_deq_cyc  = -1;
        settle();
        check_val("t3_redir_deq_valid", 32'(deq_valid),      32'd0);
        check_val("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        check_val("t3_drain_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("t3_drain_occ",       32'(occupancy),      32'd0);
        tick();
        settle();
        check_val("t3_drain2_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        settle();
        check_val("t3_run_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("t3_run_req_addr",  imem_req_addr,       32'h100);
        for (int i = 0; i < 10 && first_deq_cyc < 0; i++) tick();
        check_val("t3_first_deq", 32'(first_deq_cyc), 32'(9 - c_byp));

        // Redirect with nothing outstanding: no DRAIN, fetch resumes at once.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && occupancy != 3'd0; i++) tick();
        settle();
        check_val("t4_empty_occ", 32'(occupancy), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_pc      = 32'h0000_0200;
        tick();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        first_deq_cyc  = -1;
        base_cyc       = cyc;
        settle();
        check_val("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("t4_req_addr",  imem_req_addr,       32'h200);
        repeat (6) tick();
        check_val("t4_first_deq", 32'(first_deq_cyc - base_cyc), 32'(4 - c_byp));

        // Reset while full.
        do_reset();
        mem_lat   = 1;
        deq_ready = 1'b0;
        repeat (6) tick();
        settle();
        check_val("t5_full_occ", 32'(occupancy), 32'd4);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        exp_pc = 32'h0;
        settle();
        check_val("t5_occ",       32'(occupancy),      32'd0);
        check_val("t5_deq_valid", 32'(deq_valid),      32'd0);
        check_val("t5_req_addr",  imem_req_addr,       32'h0);
        check_val("t5_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("t5_pc",        PCF,                 32'h0);
        deq_ready = 1'b1;
        repeat (6) tick();
        check_val("t5_restart", exp_pc, (c_byp != 0) ? 32'h14 : 32'h10);

        // Single response into an empty queue (same-cycle with bypass).
        do_reset();
        mon_en     = 1'b0;
        use_force  = 1'b1;
        force_data = 32'h0050_0093;
        tick();
        imem_req_ready = 1'b0;
        settle();
        check_val("t6_c1_deq_valid", 32'(deq_valid), 32'(c_byp));
        check_val("t6_c1_instr",     InstrF,         (c_byp != 0) ? 32'h0050_0093 : c_nop);
        check_val("t6_c1_pc",        PCF,            32'h0);
        tick();
        settle();
        check_val("t6_c2_deq_valid", 32'(deq_valid), 32'(1 - c_byp));
        check_val("t6_c2_instr",     InstrF,         (c_byp != 0) ? c_nop : 32'h0050_0093);
        tick();
        settle();
        check_val("t6_occ", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
